move_key_decoder: RTL and testbench
===================================

MOVE_KEY_DECODER -- requirements
Module: move_key_decoder

Interface
REQ-001 SHALL have parameter REPEAT_FILTER, default 1, meaning 1 = ignore typematic repeat makes of an already-held direction, 0 = accept every make.
REQ-002 SHALL have ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- received_data_en  input  1  one-cycle pulse, received_data valid.
- received_data  input  8  PS/2 scancode byte.
- enable  input  1  1 = accept new moves into queue.
- move_ack  input  1  downstream consumed current move.
- move_valid  output  1  move available.
- moveUp, moveDown, moveLeft, moveRight  output  1 each  one-hot direction of current move; all 0 when move_valid=0.
- held  output  4  {up,down,left,right} keys currently held.
- drop_count  output  8  moves lost to queue overflow, saturating.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.

Function
REQ-004 SHALL map make codes: 1D/E0 75 = up, 1B/E0 72 = down, 1C/E0 6B = left, 23/E0 74 = right; all other codes SHALL be no-move.
REQ-005 SHALL run a byte-parser FSM: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); it advances only on received_data_en.
REQ-006 IDLE: E0 -> EXT; F0 -> BRK; other byte = plain make, stay IDLE.
REQ-007 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte = extended make -> IDLE.
REQ-008 BRK / EXT_BRK: any byte = plain/extended break of that code -> IDLE; no move generated.
REQ-009 A make of a mapped direction SHALL set its held bit; a break SHALL clear it; unmapped codes SHALL leave held unchanged.
REQ-010 With REPEAT_FILTER=1, a make whose held bit is already 1 SHALL generate no move; W and the up arrow share one held bit, likewise for the other directions.
REQ-011 A generated move SHALL be enqueued only if enable=1; with enable=0 it SHALL be discarded without touching drop_count. Parser and held tracking SHALL continue regardless of enable.
REQ-012 Queue: 2 entries, output slot plus pending slot, FIFO order.
REQ-013 Latency: a make byte pulsed at cycle N into an empty queue SHALL give move_valid=1 with the direction at cycle N+1.
REQ-014 move_valid and the direction outputs SHALL stay stable until move_ack=1 is sampled while move_valid=1; move_ack while move_valid=0 SHALL be ignored.
REQ-015 On ack: pending moves to output at the next cycle; if pending is empty, move_valid drops to 0 at the next cycle.
REQ-016 Simultaneous ack and new move, pending empty: the new move SHALL occupy the output at the next cycle with move_valid held at 1.
REQ-017 Simultaneous ack and new move, pending full: pending SHALL go to output and the new move to pending.
REQ-018 A new move with both slots full and no ack SHALL be dropped, and drop_count SHALL increment, saturating at 8'hFF.
REQ-019 Direction outputs SHALL be registered, not decoded combinationally from received_data.

Reset
REQ-020 On reset the parser SHALL go to IDLE; move_valid, all move* lines, held, drop_count and both queue slots SHALL be 0.
REQ-021 Reset mid-sequence, e.g. after E0, SHALL discard the partial sequence; the next byte is parsed from IDLE.

Verification
REQ-022 1D pulse at cycle 5, move_ack=0 -> at cycle 6 move_valid=1, moveUp=1, held=4'b1000; both stay until ack.
REQ-023 E0, F0, 74 after a right make -> held right bit cleared, no move generated; then E0 74 -> moveRight enqueued.
REQ-024 REPEAT_FILTER=1: 1C, 1C, 1C with no break -> exactly one moveLeft; with REPEAT_FILTER=0 -> three moves, the third dropped if unacked, drop_count=1.
REQ-025 Queue full (up, down), new make plus ack in the same cycle -> next cycle output=down, pending=the new move, drop_count unchanged.
REQ-026 enable=0, byte 23 -> held right set, move_valid stays 0, drop_count=0; reset asserted after E0, then 75 -> treated as an unmapped plain code, no move.

Source files
------------

// File: rtl/move_key_decoder.sv
// PS/2 scancode decoder turning arrow/WASD make codes into one-hot moves,
// buffered in a two-entry queue (output slot plus pending slot) with overflow counting.
module move_key_decoder #(
  parameter logic REPEAT_FILTER = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       received_data_en,
  input  logic [7:0] received_data,
  input  logic       enable,
  input  logic       move_ack,
  output logic       move_valid,
  output logic       moveUp,
  output logic       moveDown,
  output logic       moveLeft,
  output logic       moveRight,
  output logic [3:0] held,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } parseState_t;

  parseState_t state, stateNext;

  logic       makeHit;
  logic       breakHit;
  logic [3:0] byteDir;
  logic [3:0] plainDir;
  logic [3:0] extDir;
  logic [3:0] heldNext;
  logic       newMove;
  logic       push;
  logic       ackSeen;

  logic       outValid;
  logic [3:0] outDir;
  logic       pendValid;
  logic [3:0] pendDir;

  // Direction vectors are {up,down,left,right}, matching the held bit order.
  function automatic logic [3:0] decodePlain(input logic [7:0] code);
    case (code)
      8'h1D:   decodePlain = 4'b1000;
      8'h1B:   decodePlain = 4'b0100;
      8'h1C:   decodePlain = 4'b0010;
      8'h23:   decodePlain = 4'b0001;
      default: decodePlain = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] decodeExt(input logic [7:0] code);
    case (code)
      8'h75:   decodeExt = 4'b1000;
      8'h72:   decodeExt = 4'b0100;
      8'h6B:   decodeExt = 4'b0010;
      8'h74:   decodeExt = 4'b0001;
      default: decodeExt = 4'b0000;
    endcase
  endfunction

  assign plainDir = decodePlain(received_data);
  assign extDir   = decodeExt(received_data);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      held  <= 4'b0000;
    end else begin
      state <= stateNext;
      held  <= heldNext;
    end
  end

  always_comb begin
    stateNext = state;
    makeHit   = 1'b0;
    breakHit  = 1'b0;
    byteDir   = 4'b0000;
    if (received_data_en) begin
      case (state)
        IDLE: begin
          if (received_data == 8'hE0) begin
            stateNext = EXT;
          end else if (received_data == 8'hF0) begin
            stateNext = BRK;
          end else begin
            makeHit = 1'b1;
            byteDir = plainDir;
          end
        end
        EXT: begin
          if (received_data == 8'hF0) begin
            stateNext = EXT_BRK;
          end else if (received_data != 8'hE0) begin
            makeHit   = 1'b1;
            byteDir   = extDir;
            stateNext = IDLE;
          end
        end
        BRK: begin
          breakHit  = 1'b1;
          byteDir   = plainDir;
          stateNext = IDLE;
        end
        EXT_BRK: begin
          breakHit  = 1'b1;
          byteDir   = extDir;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // A held direction suppresses typematic repeats only when filtering is on.
  always_comb begin
    heldNext = held;
    if (makeHit)  heldNext = held | byteDir;
    if (breakHit) heldNext = held & ~byteDir;
    newMove = makeHit && (byteDir != 4'b0000) &&
              (!REPEAT_FILTER || ((held & byteDir) == 4'b0000));
    push    = newMove && enable;
    ackSeen = move_ack && outValid;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid   <= 1'b0;
      outDir     <= 4'b0000;
      pendValid  <= 1'b0;
      pendDir    <= 4'b0000;
      drop_count <= 8'h00;
    end else if (ackSeen) begin
      if (pendValid) begin
        outDir <= pendDir;
        if (push) begin
          pendDir <= byteDir;
        end else begin
          pendValid <= 1'b0;
          pendDir   <= 4'b0000;
        end
      end else if (push) begin
        outDir <= byteDir;
      end else begin
        outValid <= 1'b0;
        outDir   <= 4'b0000;
      end
    end else if (push) begin
      if (!outValid) begin
        outValid <= 1'b1;
        outDir   <= byteDir;
      end else if (!pendValid) begin
        pendValid <= 1'b1;
        pendDir   <= byteDir;
      end else if (drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  assign move_valid = outValid;
  assign moveUp     = outValid & outDir[3];
  assign moveDown   = outValid & outDir[2];
  assign moveLeft   = outValid & outDir[1];
  assign moveRight  = outValid & outDir[0];

endmodule

// File: tb/tb_move_key_decoder.sv
// Directed bench for move_key_decoder; a filtering and a non-filtering instance share stimulus.
module tb_move_key_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       received_data_en = 1'b0;
  logic [7:0] received_data = 8'h00;
  logic       enable = 1'b1;
  logic       move_ack = 1'b0;

  logic       fValid, fUp, fDown, fLeft, fRight;
  logic [3:0] fHeld;
  logic [7:0] fDrop;
  logic       rValid, rUp, rDown, rLeft, rRight;
  logic [3:0] rHeld;
  logic [7:0] rDrop;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  move_key_decoder #(.REPEAT_FILTER(1'b1)) dutFilt (
    .clock(clock), .reset(reset), .received_data_en(received_data_en),
    .received_data(received_data), .enable(enable), .move_ack(move_ack),
    .move_valid(fValid), .moveUp(fUp), .moveDown(fDown), .moveLeft(fLeft),
    .moveRight(fRight), .held(fHeld), .drop_count(fDrop)
  );

  move_key_decoder #(.REPEAT_FILTER(1'b0)) dutRaw (
    .clock(clock), .reset(reset), .received_data_en(received_data_en),
    .received_data(received_data), .enable(enable), .move_ack(move_ack),
    .move_valid(rValid), .moveUp(rUp), .moveDown(rDown), .moveLeft(rLeft),
    .moveRight(rRight), .held(rHeld), .drop_count(rDrop)
  );

  // Inputs change on falling edges, so every check lands mid-cycle after the rising edge.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clock);
    received_data    = b;
    received_data_en = 1'b1;
    @(negedge clock);
    received_data_en = 1'b0;
  endtask

  task automatic doAck();
    @(negedge clock);
    move_ack = 1'b1;
    @(negedge clock);
    move_ack = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    compared++; if ({fValid, fUp, fDown, fLeft, fRight} !== 5'b0) begin mismatched++; $display("[TB] FAIL reset_out got=%b want=00000", {fValid, fUp, fDown, fLeft, fRight}); end
    compared++; if (fHeld !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_held got=%b want=0000", fHeld); end
    compared++; if (fDrop !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_drop got=%h want=00", fDrop); end
  endtask

  task automatic test_up_make();
    doReset();
    repeat (3) @(negedge clock);
    sendByte(8'h1D);
    compared++; if ({fValid, fUp, fDown, fLeft, fRight} !== 5'b11000) begin mismatched++; $display("[TB] FAIL up_out got=%b want=11000", {fValid, fUp, fDown, fLeft, fRight}); end
    compared++; if (fHeld !== 4'b1000) begin mismatched++; $display("[TB] FAIL up_held got=%b want=1000", fHeld); end
    repeat (4) @(negedge clock);
    compared++; if ({fValid, fUp} !== 2'b11) begin mismatched++; $display("[TB] FAIL up_stable got=%b want=11", {fValid, fUp}); end
    doAck();
    compared++; if ({fValid, fUp} !== 2'b00) begin mismatched++; $display("[TB] FAIL up_acked got=%b want=00", {fValid, fUp}); end
    sendByte(8'hF0); sendByte(8'h1D);
    compared++; if (fHeld !== 4'b0000 || fValid !== 1'b0) begin mismatched++; $display("[TB] FAIL up_break held=%b valid=%b want 0000/0", fHeld, fValid); end
  endtask

  task automatic test_ext_break();
    doReset();
    sendByte(8'h23);
    compared++; if ({fValid, fRight} !== 2'b11 || fHeld !== 4'b0001) begin mismatched++; $display("[TB] FAIL right_make vr=%b held=%b want 11/0001", {fValid, fRight}, fHeld); end
    doAck();
    sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h74);
    compared++; if (fHeld !== 4'b0000 || fValid !== 1'b0) begin mismatched++; $display("[TB] FAIL ext_break held=%b valid=%b want 0000/0", fHeld, fValid); end
    sendByte(8'hE0); sendByte(8'h74);
    compared++; if ({fValid, fUp, fDown, fLeft, fRight} !== 5'b10001) begin mismatched++; $display("[TB] FAIL ext_right got=%b want=10001", {fValid, fUp, fDown, fLeft, fRight}); end
    doAck();
  endtask

  task automatic test_repeat_filter();
    doReset();
    sendByte(8'h1C); sendByte(8'h1C); sendByte(8'h1C);
    compared++; if ({fValid, fLeft} !== 2'b11 || fDrop !== 8'h00) begin mismatched++; $display("[TB] FAIL filt_first vl=%b drop=%h want 11/00", {fValid, fLeft}, fDrop); end
    compared++; if ({rValid, rLeft} !== 2'b11 || rDrop !== 8'h01) begin mismatched++; $display("[TB] FAIL raw_drop vl=%b drop=%h want 11/01", {rValid, rLeft}, rDrop); end
    doAck();
    compared++; if (fValid !== 1'b0) begin mismatched++; $display("[TB] FAIL filt_single got=%b want=0", fValid); end
    compared++; if ({rValid, rLeft} !== 2'b11) begin mismatched++; $display("[TB] FAIL raw_second got=%b want=11", {rValid, rLeft}); end
    doAck();
    compared++; if (rValid !== 1'b0) begin mismatched++; $display("[TB] FAIL raw_empty got=%b want=0", rValid); end
  endtask

  task automatic test_back_to_back();
    doReset();
    sendByte(8'h1D); sendByte(8'h1B);
    compared++; if ({fValid, fUp, fDown} !== 3'b110) begin mismatched++; $display("[TB] FAIL full_out got=%b want=110", {fValid, fUp, fDown}); end
    @(negedge clock);
    received_data = 8'h1C; received_data_en = 1'b1; move_ack = 1'b1;
    @(negedge clock);
    received_data_en = 1'b0; move_ack = 1'b0;
    compared++; if ({fValid, fUp, fDown, fLeft, fRight} !== 5'b10100 || fDrop !== 8'h00) begin mismatched++; $display("[TB] FAIL ack_push out=%b drop=%h want 10100/00", {fValid, fUp, fDown, fLeft, fRight}, fDrop); end
    doAck();
    compared++; if ({fValid, fUp, fDown, fLeft, fRight} !== 5'b10010) begin mismatched++; $display("[TB] FAIL pend_left got=%b want=10010", {fValid, fUp, fDown, fLeft, fRight}); end
    @(negedge clock);
    received_data = 8'h23; received_data_en = 1'b1; move_ack = 1'b1;
    @(negedge clock);
    received_data_en = 1'b0; move_ack = 1'b0;
    compared++; if ({fValid, fUp, fDown, fLeft, fRight} !== 5'b10001) begin mismatched++; $display("[TB] FAIL ack_push_empty got=%b want=10001", {fValid, fUp, fDown, fLeft, fRight}); end
    doAck();
    compared++; if (fValid !== 1'b0) begin mismatched++; $display("[TB] FAIL drained got=%b want=0", fValid); end
    doAck();
    sendByte(8'hE0); sendByte(8'hE0); sendByte(8'h72);
    compared++; if (fValid !== 1'b0 || fHeld !== 4'b1111) begin mismatched++; $display("[TB] FAIL e0e0_held_down valid=%b held=%b want 0/1111", fValid, fHeld); end
    sendByte(8'h55);
    compared++; if (fHeld !== 4'b1111 || fValid !== 1'b0) begin mismatched++; $display("[TB] FAIL unmapped held=%b valid=%b want 1111/0", fHeld, fValid); end
  endtask

  task automatic test_drop_saturate();
    doReset();
    sendByte(8'h1D); sendByte(8'h1B);
    sendByte(8'h1C);
    for (int i = 0; i < 2; i++) begin
      sendByte(8'hF0); sendByte(8'h1C); sendByte(8'h1C);
    end
    compared++; if (fDrop !== 8'h03) begin mismatched++; $display("[TB] FAIL drop_three got=%h want=03", fDrop); end
    for (int i = 0; i < 260; i++) begin
      sendByte(8'hF0); sendByte(8'h1C); sendByte(8'h1C);
    end
    compared++; if (fDrop !== 8'hFF) begin mismatched++; $display("[TB] FAIL drop_sat got=%h want=FF", fDrop); end
    compared++; if ({fValid, fUp} !== 2'b11) begin mismatched++; $display("[TB] FAIL drop_keeps_out got=%b want=11", {fValid, fUp}); end
  endtask

  task automatic test_enable_and_reset_mid();
    doReset();
    enable = 1'b0;
    sendByte(8'h23);
    compared++; if (fHeld !== 4'b0001 || fValid !== 1'b0 || fDrop !== 8'h00) begin mismatched++; $display("[TB] FAIL enable_off held=%b valid=%b drop=%h want 0001/0/00", fHeld, fValid, fDrop); end
    enable = 1'b1;
    sendByte(8'hE0);
    doReset();
    sendByte(8'h75);
    compared++; if (fValid !== 1'b0 || fHeld !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_mid valid=%b held=%b want 0/0000", fValid, fHeld); end
    doAck();
    sendByte(8'hE0); sendByte(8'h75);
    compared++; if ({fValid, fUp} !== 2'b11) begin mismatched++; $display("[TB] FAIL after_reset_ext got=%b want=11", {fValid, fUp}); end
  endtask

  initial begin
    test_reset();
    test_up_make();
    test_ext_break();
    test_repeat_filter();
    test_back_to_back();
    test_drop_saturate();
    test_enable_and_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
